uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter: serialises DBIT-wide words with runtime-selectable parity (none/even/odd)
//  and 1 or 2 stop bits, oversampled by OS_TICK baud ticks per bit. Fed by a valid/ready word interface

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_cfg.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions for the transmitter and receiver.
//   - uart_state_e : frame sequencing states
//   - PAR_*        : par_mode encodings (2'b11 is reserved and behaves as PAR_NONE)
//   - par_enabled  : true when a mode inserts a parity bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous FIFO in front of the UART transmitter. Show-ahead: rdata is
//   always the oldest entry while not empty.
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active low (empties the FIFO)
//   push     in   write wdata (ignored when full, even with a same-cycle pop)
//   wdata    in   W-bit word
//   pop      in   discard head entry (ignored when empty)
//   rdata    out  head entry
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  number of stored entries
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   UART transmitter: START, DBIT data bits LSB first, optional parity
//   (even/odd), one or two STOP bits. Each bit lasts OS_TICK s_tick pulses.
//   par_mode and stop2 are captured together with the word at frame start.
//   Build option UART_TX_FIFO_EN: FIFO_DEPTH-entry input FIFO (uart_tx_fifo),
//   allowing back-to-back frames. Without it a single holding register is
//   used and din is only accepted while IDLE.
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous reset, active low; abandons any frame
//   s_tick     in   baud oversampling strobe, one clk wide
//   din_valid  in   word offered on din
//   din        in   DBIT-bit word
//   din_ready  out  word accepted when din_valid & din_ready at a rising edge
//   par_mode   in   00 none, 01 even, 10 odd, 11 none
//   stop2      in   0: one stop bit, 1: two stop bits
//   tx         out  serial line, idle high, registered
//   tx_busy    out  high while a frame is on the line, registered
//   tx_done    out  one-cycle pulse after the last stop tick, registered
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit, only when par_mode selects even/odd
// STOP   | one or two stop bit periods (high)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OS_TICK    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            din_valid,
  input  logic [DBIT-1:0] din,
  output logic            din_ready,
  input  logic [1:0]      par_mode,
  input  logic            stop2,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int SW = $clog2(OS_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_LAST   = SW'(OS_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
  localparam logic [SW:0]   SC_LAST1 = (SW+1)'(OS_TICK - 1);
  localparam logic [SW:0]   SC_LAST2 = (SW+1)'(2*OS_TICK - 1);

  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_tx_cfg: DBIT must be 5..9");
  end
  if (OS_TICK < 8 || OS_TICK > 32) begin : g_bad_os
    $error("uart_tx_cfg: OS_TICK must be 8..32");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [SW:0]     sc_q, sc_d;       // stop counter spans up to two bit periods
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] word_q, word_d;   // unshifted copy for parity
  logic [1:0]      par_q, par_d;
  logic            stop2_q, stop2_d;
  logic            tx_d;
  logic            done_d;
  logic            load;
  logic            par_bit;
  logic            word_avail;
  logic [DBIT-1:0] word_head;

`ifdef UART_TX_FIFO_EN
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  uart_tx_fifo #(
    .W     (DBIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (din_valid & ~fifo_full),
    .wdata   (din),
    .pop     (load),
    .rdata   (word_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // count is a register, so din_ready carries no combinational input path.
  assign din_ready  = (fifo_count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign word_avail = ~fifo_empty;
`else
  // The frame registers double as the holding register; a word is only
  // taken while IDLE, which forces an IDLE cycle between frames.
  assign din_ready  = (state_q == IDLE);
  assign word_avail = din_valid & din_ready;
  assign word_head  = din;
`endif

  assign par_bit = (par_q == PAR_ODD) ? ~^word_q : ^word_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sc_d    = sc_q;
    n_d     = n_q;
    shift_d = shift_q;
    word_d  = word_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (word_avail) load = 1'b1;
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              sc_d    = '0;
              state_d = par_enabled(par_q) ? PARITY : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            sc_d    = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (sc_q == (stop2_q ? SC_LAST2 : SC_LAST1)) begin
            sc_d   = '0;
            done_d = 1'b1;
            if (word_avail) load = 1'b1;
            else            state_d = IDLE;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame captures word and frame format together, so later changes
    // of par_mode/stop2 cannot affect it.
    if (load) begin
      state_d = START;
      s_d     = '0;
      word_d  = word_head;
      shift_d = word_head;
      par_d   = par_mode;
      stop2_d = stop2;
    end

    // tx shows the level of the bit being entered on this edge.
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      sc_q    <= '0;
      n_q     <= '0;
      shift_q <= '0;
      word_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sc_q    <= sc_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx      <= tx_d;
      tx_busy <= (state_d != IDLE);
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
//   Self-checking bench for uart_tx_cfg (DBIT=8, OS_TICK=16, s_tick every 4 clk).
//   A frame-level model (bit list + elapsed tick count + word queue) predicts
//   tx/tx_busy/tx_done/din_ready every cycle; directed frames are also checked
//   against hand-computed bit patterns. Works with or without UART_TX_FIFO_EN.
module tb_uart_tx_cfg;

  localparam int DBIT       = 8;
  localparam int OS_TICK    = 16;
  localparam int FIFO_DEPTH = 4;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       s_tick    = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din       = 8'h00;
  logic [1:0] par_mode  = 2'b00;
  logic       stop2     = 1'b0;
  logic       din_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_cfg #(
    .DBIT       (DBIT),
    .OS_TICK    (OS_TICK),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tick    (s_tick),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .par_mode  (par_mode),
    .stop2     (stop2),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  function automatic void check(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  // Frame as a list of bit levels, each OS_TICK ticks long.
  function automatic void build(input logic [7:0] w, input logic [1:0] pm, input logic s2,
                                output logic [15:0] lv, output int len);
    int nb;
    lv    = '1;
    lv[0] = 1'b0;
    for (int i = 0; i < DBIT; i++) lv[1+i] = w[i];
    nb = 1 + DBIT;
    if (pm == 2'b01) begin
      lv[nb] = ^w;
      nb++;
    end else if (pm == 2'b10) begin
      lv[nb] = ~^w;
      nb++;
    end
    nb  = nb + (s2 ? 2 : 1);
    len = nb * OS_TICK;
  endfunction

  // ---------------- model ----------------
  bit          m_active = 1'b0;
  int          m_ticks  = 0;
  int          m_len    = 0;
  logic [15:0] m_lv     = '1;
  logic [7:0]  m_q[$];
  bit          m_done   = 1'b0;
  bit          m_ready  = 1'b1;
  bit          m_acc;
  logic [7:0]  m_w;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_ticks  = 0;
      m_q.delete();
      m_done   = 1'b0;
      m_ready  = 1'b1;
    end else begin
      m_acc  = din_valid && m_ready;
      m_done = 1'b0;
      if (m_active && s_tick) begin
        m_ticks++;
        if (m_ticks == m_len) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
`ifdef UART_TX_FIFO_EN
      if (!m_active && m_q.size() > 0) begin
        m_w = m_q.pop_front();
        build(m_w, par_mode, stop2, m_lv, m_len);
        m_active = 1'b1;
        m_ticks  = 0;
      end
      if (m_acc) m_q.push_back(din);
      m_ready = (m_q.size() != FIFO_DEPTH);
`else
      if (m_acc) begin
        build(din, par_mode, stop2, m_lv, m_len);
        m_active = 1'b1;
        m_ticks  = 0;
      end
      m_ready = !m_active;
`endif
    end
  end

  always @(negedge clk) begin
    check("tx", tx, m_active ? m_lv[m_ticks / OS_TICK] : 1'b1);
    check("tx_busy", tx_busy, m_active);
    check("tx_done", tx_done, m_done);
    check("din_ready", din_ready, m_ready);
  end

  // ---------------- recorder ----------------
  bit   rec_en     = 1'b0;
  logic rec_q[$];
  int   done_cnt   = 0;
  int   gap        = 0;
  int   rec_frames = 1;
  int   not_ready  = 0;

  always @(negedge clk) begin
    if (rec_en) begin
      if (tx_busy && s_tick) rec_q.push_back(tx);
      if (tx_done) done_cnt++;
      if (!tx_busy && done_cnt >= 1 && done_cnt < rec_frames) gap++;
      if (din_valid && !din_ready) not_ready++;
    end
  end

  task automatic rec_clear(input int frames);
    rec_q.delete();
    done_cnt   = 0;
    gap        = 0;
    not_ready  = 0;
    rec_frames = frames;
  endtask

  task automatic send(input logic [7:0] w, input logic [1:0] pm, input logic s2);
    int c;
    bit r;
    c = 0;
    r = 1'b0;
    din       = w;
    par_mode  = pm;
    stop2     = s2;
    din_valid = 1'b1;
    while (!r && c < 5000) begin
      @(negedge clk);
      r = din_ready;
      @(posedge clk);
      #1;
      c++;
    end
    din_valid = 1'b0;
    if (!r) begin
      n_vec++;
      n_err++;
      $display("FAIL send_%0h: din_ready never high within %0d cycles", w, c);
    end
`ifndef UART_TX_FIFO_EN
    // Format is captured at accept; disturbing it now must not matter.
    par_mode = ~pm;
    stop2    = ~s2;
    din      = ~w;
`endif
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int c;
    c = 0;
    while ((m_active || m_q.size() != 0 || tx_busy) && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= maxc) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles", nm, c);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm, input int off, input logic [15:0] pat, input int nb);
    for (int k = 0; k < nb; k++) begin
      int idx;
      idx = off + OS_TICK * k + OS_TICK / 2;
      if (idx < rec_q.size()) begin
        check($sformatf("%s_bit%0d", nm, k), rec_q[idx], pat[k]);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL %s_bit%0d: no sample recorded, required %b", nm, k, pat[k]);
      end
    end
  endtask

  task automatic run_frame(input string nm, input logic [7:0] w, input logic [1:0] pm,
                           input logic s2, input logic [15:0] pat, input int nb);
    rec_clear(1);
    rec_en = 1'b1;
    send(w, pm, s2);
    wait_idle(nm, 3000);
    rec_en = 1'b0;
    check_int({nm, "_busy_ticks"}, rec_q.size(), nb * OS_TICK);
    check_int({nm, "_done_pulses"}, done_cnt, 1);
    check_frame(nm, 0, pat, nb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] lv;
    int          len;

    // Pin the model against hand-worked frames.
    build(8'hA5, 2'b00, 1'b0, lv, len);
    check_int("model_a5_none_bits", int'(lv[9:0]), 'h34A);
    check_int("model_a5_none_len", len, 160);
    build(8'hA5, 2'b10, 1'b0, lv, len);
    check_int("model_a5_odd_bits", int'(lv[10:0]), 'h74A);
    check_int("model_a5_odd_len", len, 176);

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ready", din_ready, 1'b1);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    run_frame("a5_none",   8'hA5, 2'b00, 1'b0, 16'h034A, 10);
    run_frame("a5_even",   8'hA5, 2'b01, 1'b0, 16'h054A, 11);
    run_frame("a5_odd",    8'hA5, 2'b10, 1'b0, 16'h074A, 11);
    run_frame("3c_stop2",  8'h3C, 2'b00, 1'b1, 16'h0678, 11);
    run_frame("a5_resvd",  8'hA5, 2'b11, 1'b0, 16'h034A, 10);

    // Reset during data bit 3.
    begin
      int c;
      c = 0;
      send(8'hF0, 2'b00, 1'b0);
      while (!(m_active && m_ticks >= 4 * OS_TICK + 6) && c < 2000) begin
        @(posedge clk);
        #1;
        c++;
      end
      check("mid_reset_reached_bit3", (c < 2000), 1'b1);
      reset_n = 1'b0;
      #1;
      check("mid_reset_tx", tx, 1'b1);
      check("mid_reset_busy", tx_busy, 1'b0);
      check("mid_reset_done", tx_done, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
    run_frame("55_after_rst", 8'h55, 2'b00, 1'b0, 16'h02AA, 10);

`ifdef UART_TX_FIFO_EN
    rec_clear(6);
    rec_en = 1'b1;
    for (int i = 1; i <= 6; i++) send(8'(i), 2'b00, 1'b0);
    wait_idle("fifo6", 8000);
    rec_en = 1'b0;
    check_int("fifo6_done_pulses", done_cnt, 6);
    check_int("fifo6_busy_ticks", rec_q.size(), 6 * 10 * OS_TICK);
    check_int("fifo6_idle_gaps", gap, 0);
    check("fifo6_ready_went_low", (not_ready > 0), 1'b1);
    for (int i = 1; i <= 6; i++)
      check_frame($sformatf("fifo6_f%0d", i), (i - 1) * 10 * OS_TICK, 16'h200 | 16'(i << 1), 10);
`else
    begin
      int  c;
      int  a;
      bit  r;
      rec_clear(2);
      rec_en    = 1'b1;
      din       = 8'h81;
      par_mode  = 2'b00;
      stop2     = 1'b0;
      din_valid = 1'b1;
      c = 0;
      a = 0;
      while (a < 2 && c < 4000) begin
        @(negedge clk);
        r = din_ready;
        @(posedge clk);
        #1;
        if (r) a++;
        c++;
      end
      din_valid = 1'b0;
      check_int("hold81_accepts", a, 2);
      wait_idle("hold81", 3000);
      rec_en = 1'b0;
      check_int("hold81_done_pulses", done_cnt, 2);
      check_int("hold81_busy_ticks", rec_q.size(), 2 * 10 * OS_TICK);
      check("hold81_idle_between", (gap >= 1), 1'b1);
      check("hold81_ready_low_busy", (not_ready > 0), 1'b1);
      check_frame("hold81_f1", 0, 16'h0302, 10);
      check_frame("hold81_f2", 10 * OS_TICK, 16'h0302, 10);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
